// File: rtl/drp_responder.sv
// DRP slave emulating the PLLE2_ADV reconfiguration port: register file, fixed drdy latency, lock model.
// Optional DRP_WRITE_LOCK_EN: reject writes that complete while the modelled PLL is running.
module drp_responder #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 16,
    parameter int RDY_LATENCY = 3,
    parameter int LOCK_DELAY  = 64
) (
    input  logic              dclk,
    input  logic              rst_n,
    input  logic              den,
    input  logic              dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              drdy,
    input  logic              rst_pll,
    output logic              locked,
    output logic              proto_err,
    output logic [7:0]        access_cnt
);
    localparam int         LCW    = $clog2(LOCK_DELAY + 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;
    localparam logic [3:0] LAT_M1 = 4'(RDY_LATENCY - 1);

    logic [0:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_dout;
    logic              r_drdy;
    logic              r_perr;
    logic [7:0]        r_acc;
    logic [LCW-1:0]    r_lcnt;
    logic              r_locked;

    logic              w_accept;
    logic              w_collide;
    logic              w_done;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;
    logic              w_wr_ok;

    // A den in the drdy cycle is treated as arriving while busy.
    assign w_accept  = den && (r_state == S_IDLE) && !r_drdy;
    assign w_collide = den && !w_accept;
    // The completion edge is the one that takes the counter to 0; latency 1 completes on the den edge.
    assign w_done    = ((r_state == S_BUSY) && (r_cnt == 4'd1)) || (w_accept && (LAT_M1 == 4'd0));
    assign w_we      = (LAT_M1 == 4'd0) ? dwe   : r_we;
    assign w_addr    = (LAT_M1 == 4'd0) ? daddr : r_addr;
    assign w_din     = (LAT_M1 == 4'd0) ? din   : r_din;

`ifdef DRP_WRITE_LOCK_EN
    assign w_wr_ok = rst_pll;
`else
    assign w_wr_ok = 1'b1;
`endif

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_dout  <= '0;
            r_drdy  <= 1'b0;
            r_perr  <= 1'b0;
            r_acc   <= '0;
            for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
        end else begin
            r_drdy <= w_done;
            if (w_collide) r_perr <= 1'b1;
            if (w_accept) begin
                r_we    <= dwe;
                r_addr  <= daddr;
                r_din   <= din;
                r_cnt   <= LAT_M1;
                r_state <= (LAT_M1 == 4'd0) ? S_IDLE : S_BUSY;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) r_state <= S_IDLE;
            end
            if (w_done) begin
                r_acc <= r_acc + 8'd1;
                if (!w_we)        r_dout <= r_mem[w_addr];
                else if (w_wr_ok) r_mem[w_addr] <= w_din;
                else              r_perr <= 1'b1;
            end
        end
    end

    // Lock counter saturates at LOCK_DELAY; locked registers one edge after the count hits LOCK_DELAY-1.
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_lcnt   <= '0;
            r_locked <= 1'b0;
        end else if (rst_pll) begin
            r_lcnt   <= '0;
            r_locked <= 1'b0;
        end else begin
            if (r_lcnt != LCW'(LOCK_DELAY)) r_lcnt <= r_lcnt + 1'b1;
            r_locked <= (r_lcnt >= LCW'(LOCK_DELAY - 1));
        end
    end

    assign dout       = r_dout;
    assign drdy       = r_drdy;
    assign locked     = r_locked;
    assign proto_err  = r_perr;
    assign access_cnt = r_acc;
endmodule

// File: tb/tb_drp_responder.sv
// Directed bench for drp_responder: latency-3 instance driven from a vector table,
// latency-1 instance for minimum latency, write-lock and counter wrap; plus lock and reset sequences.
module tb_drp_responder;
    logic dclk = 1'b0;
    always #5 dclk = ~dclk;

    logic        rst_n, rst_pll, a_den, b_den, dwe;
    logic [6:0]  daddr;
    logic [15:0] din;
    logic [15:0] a_dout, b_dout;
    logic        a_drdy, b_drdy, a_locked, b_locked, a_perr, b_perr;
    logic [7:0]  a_acc, b_acc;

    drp_responder #(.ADDR_W(7), .DATA_W(16), .RDY_LATENCY(3), .LOCK_DELAY(64)) u_a (
        .dclk(dclk), .rst_n(rst_n), .den(a_den), .dwe(dwe), .daddr(daddr), .din(din),
        .dout(a_dout), .drdy(a_drdy), .rst_pll(rst_pll), .locked(a_locked),
        .proto_err(a_perr), .access_cnt(a_acc));

    drp_responder #(.ADDR_W(7), .DATA_W(16), .RDY_LATENCY(1), .LOCK_DELAY(64)) u_b (
        .dclk(dclk), .rst_n(rst_n), .den(b_den), .dwe(dwe), .daddr(daddr), .din(din),
        .dout(b_dout), .drdy(b_drdy), .rst_pll(rst_pll), .locked(b_locked),
        .proto_err(b_perr), .access_cnt(b_acc));

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        den;
        logic        we;
        logic [6:0]  addr;
        logic [15:0] din;
        logic        e_drdy;
        logic [15:0] e_dout;
        logic        e_perr;
        logic [7:0]  e_acc;
    } vec_t;

    function automatic vec_t mk(input logic dn, input logic w, input logic [6:0] a, input logic [15:0] d,
                                input logic ry, input logic [15:0] o, input logic pe, input logic [7:0] ac);
        vec_t v;
        v.den = dn; v.we = w; v.addr = a; v.din = d;
        v.e_drdy = ry; v.e_dout = o; v.e_perr = pe; v.e_acc = ac;
        return v;
    endfunction

    vec_t tbl[24];

    logic [15:0] b_dout_exp;
    logic [7:0]  b_acc_exp;
    logic        b_perr_exp;

    // One latency-1 transaction: den in this cycle, drdy expected in the next.
    task automatic b_txn(input logic we, input logic [6:0] a, input logic [15:0] d, input logic [15:0] rd);
        @(negedge dclk);
        b_den = 1'b1; dwe = we; daddr = a; din = d;
        chk("b_drdy_low", {31'd0, b_drdy}, 32'd0);
        @(negedge dclk);
        b_den = 1'b0;
        b_acc_exp = b_acc_exp + 8'd1;
        if (!we) b_dout_exp = rd;
        chk("b_drdy", {31'd0, b_drdy}, 32'd1);
        chk("b_dout", {16'd0, b_dout}, {16'd0, b_dout_exp});
        chk("b_acc", {24'd0, b_acc}, {24'd0, b_acc_exp});
        chk("b_perr", {31'd0, b_perr}, {31'd0, b_perr_exp});
    endtask

    // Steps n cycles after a release of rst_pll, checking locked against its exact rise cycle.
    task automatic lock_run(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge dclk);
            chk($sformatf("lock_k%0d", k), {31'd0, a_locked}, (k >= 64) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 1, 7'h08, 16'h1041, 0, 16'h0000, 0, 8'd0);
        tbl[1]  = mk(0, 0, 7'h00, 16'h0000, 0, 16'h0000, 0, 8'd0);
        tbl[2]  = mk(0, 0, 7'h00, 16'h0000, 0, 16'h0000, 0, 8'd0);
        tbl[3]  = mk(0, 0, 7'h00, 16'h0000, 1, 16'h0000, 0, 8'd1);
        tbl[4]  = mk(1, 0, 7'h08, 16'h0000, 0, 16'h0000, 0, 8'd1);
        tbl[5]  = mk(0, 0, 7'h00, 16'h0000, 0, 16'h0000, 0, 8'd1);
        tbl[6]  = mk(0, 0, 7'h00, 16'h0000, 0, 16'h0000, 0, 8'd1);
        tbl[7]  = mk(0, 0, 7'h00, 16'h0000, 1, 16'h1041, 0, 8'd2);
        tbl[8]  = mk(1, 1, 7'h10, 16'h1234, 0, 16'h1041, 0, 8'd2);
        tbl[9]  = mk(1, 1, 7'h10, 16'hDEAD, 0, 16'h1041, 0, 8'd2);
        tbl[10] = mk(0, 0, 7'h00, 16'h0000, 0, 16'h1041, 1, 8'd2);
        tbl[11] = mk(1, 1, 7'h10, 16'hBEEF, 1, 16'h1041, 1, 8'd3);
        tbl[12] = mk(1, 0, 7'h10, 16'h0000, 0, 16'h1041, 1, 8'd3);
        tbl[13] = mk(0, 0, 7'h00, 16'h0000, 0, 16'h1041, 1, 8'd3);
        tbl[14] = mk(0, 0, 7'h00, 16'h0000, 0, 16'h1041, 1, 8'd3);
        tbl[15] = mk(0, 0, 7'h00, 16'h0000, 1, 16'h1234, 1, 8'd4);
        tbl[16] = mk(1, 1, 7'h11, 16'h5A5A, 0, 16'h1234, 1, 8'd4);
        tbl[17] = mk(0, 0, 7'h00, 16'h0000, 0, 16'h1234, 1, 8'd4);
        tbl[18] = mk(0, 0, 7'h00, 16'h0000, 0, 16'h1234, 1, 8'd4);
        tbl[19] = mk(0, 0, 7'h00, 16'h0000, 1, 16'h1234, 1, 8'd5);
        tbl[20] = mk(1, 0, 7'h11, 16'h0000, 0, 16'h1234, 1, 8'd5);
        tbl[21] = mk(0, 0, 7'h00, 16'h0000, 0, 16'h1234, 1, 8'd5);
        tbl[22] = mk(0, 0, 7'h00, 16'h0000, 0, 16'h1234, 1, 8'd5);
        tbl[23] = mk(0, 0, 7'h00, 16'h0000, 1, 16'h5A5A, 1, 8'd6);

        rst_n = 1'b0; rst_pll = 1'b1; a_den = 1'b0; b_den = 1'b0;
        dwe = 1'b0; daddr = '0; din = '0;
        b_dout_exp = '0; b_acc_exp = '0; b_perr_exp = 1'b0;
        repeat (2) @(negedge dclk);
        chk("rst_drdy", {31'd0, a_drdy}, 32'd0);
        chk("rst_dout", {16'd0, a_dout}, 32'd0);
        chk("rst_locked", {31'd0, a_locked}, 32'd0);
        chk("rst_perr", {31'd0, a_perr}, 32'd0);
        chk("rst_acc", {24'd0, a_acc}, 32'd0);
        rst_n = 1'b1;

        // Latency 3: write/readback, busy collisions, writes leaving dout alone.
        for (int i = 0; i < 24; i++) begin
            @(negedge dclk);
            a_den = tbl[i].den; dwe = tbl[i].we; daddr = tbl[i].addr; din = tbl[i].din;
            chk($sformatf("v%0d_drdy", i), {31'd0, a_drdy}, {31'd0, tbl[i].e_drdy});
            chk($sformatf("v%0d_dout", i), {16'd0, a_dout}, {16'd0, tbl[i].e_dout});
            chk($sformatf("v%0d_perr", i), {31'd0, a_perr}, {31'd0, tbl[i].e_perr});
            chk($sformatf("v%0d_acc", i), {24'd0, a_acc}, {24'd0, tbl[i].e_acc});
            chk($sformatf("v%0d_locked", i), {31'd0, a_locked}, 32'd0);
        end
        @(negedge dclk);
        a_den = 1'b0;

        // Latency 1 back-to-back at both address extremes.
        b_txn(1'b1, 7'h00, 16'hAAAA, 16'h0000);
        b_txn(1'b1, 7'h7F, 16'h5555, 16'h0000);
        b_txn(1'b0, 7'h00, 16'h0000, 16'hAAAA);
        b_txn(1'b0, 7'h7F, 16'h0000, 16'h5555);

        // Lock: clean release, then drop after rst_pll rises.
        @(negedge dclk);
        rst_pll = 1'b0;
        lock_run(64);
        rst_pll = 1'b1;
        @(negedge dclk);
        chk("lock_drop", {31'd0, a_locked}, 32'd0);
        // Release, one-cycle pulse 30 cycles in, count restarts from the new release.
        rst_pll = 1'b0;
        lock_run(30);
        rst_pll = 1'b1;
        @(negedge dclk);
        chk("lock_pulse", {31'd0, a_locked}, 32'd0);
        rst_pll = 1'b0;
        lock_run(64);

        // Write while the PLL runs (rst_pll=0), then while held in reset.
`ifdef DRP_WRITE_LOCK_EN
        b_perr_exp = 1'b1;
        b_txn(1'b1, 7'h14, 16'hBEEF, 16'h0000);
        b_txn(1'b0, 7'h14, 16'h0000, 16'h0000);
`else
        b_txn(1'b1, 7'h14, 16'hBEEF, 16'h0000);
        b_txn(1'b0, 7'h14, 16'h0000, 16'hBEEF);
`endif
        rst_pll = 1'b1;
        b_txn(1'b1, 7'h14, 16'hBEEF, 16'h0000);
        b_txn(1'b0, 7'h14, 16'h0000, 16'hBEEF);

        // 256 more completions: access_cnt must pass through 8'hFF -> 8'h00.
        for (int n = 0; n < 256; n++) b_txn(1'b0, 7'h00, 16'h0000, 16'hAAAA);

        // rst_n between den and drdy aborts the write.
        @(negedge dclk);
        a_den = 1'b1; dwe = 1'b1; daddr = 7'h20; din = 16'h1111;
        @(negedge dclk);
        a_den = 1'b0; rst_n = 1'b0;
        @(negedge dclk);
        chk("mid_acc", {24'd0, a_acc}, 32'd0);
        chk("mid_perr", {31'd0, a_perr}, 32'd0);
        chk("mid_locked", {31'd0, a_locked}, 32'd0);
        chk("mid_drdy", {31'd0, a_drdy}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge dclk);
            chk($sformatf("mid_nodrdy%0d", k), {31'd0, a_drdy}, 32'd0);
        end
        @(negedge dclk);
        a_den = 1'b1; dwe = 1'b0; daddr = 7'h20;
        @(negedge dclk);
        a_den = 1'b0;
        repeat (2) @(negedge dclk);
        chk("mid_rd_drdy", {31'd0, a_drdy}, 32'd1);
        chk("mid_rd_dout", {16'd0, a_dout}, 32'd0);
        chk("mid_rd_acc", {24'd0, a_acc}, 32'd1);
        chk("mid_rd_perr", {31'd0, a_perr}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/drp_responder.md
Name: drp_responder

Overview:
- Synthesizable DRP slave. Emulates the PLLE2_ADV dynamic-reconfiguration port and its lock behaviour.
- Answers den/dwe/daddr/din with drdy/dout from an internal 2^ADDR_W x DATA_W register file.
- Models LOCKED around rst_pll.
- Stands in for the PLL primitive when testing reconfiguration initiators in simulation and on fabric, where the bus can be probed.

Parameters:
- ADDR_W, 7: DRP address width; register file depth is 2^ADDR_W.
- DATA_W, 16: DRP data width.
- RDY_LATENCY, 3: cycles from the den cycle to the drdy cycle; legal range 1..15.
- LOCK_DELAY, 64: dclk cycles from rst_pll deassertion to locked assertion; must be >= 1.

Ports:
- dclk, input, 1: sole clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- den, input, 1: DRP enable, single-cycle request strobe.
- dwe, input, 1: write enable, sampled with den.
- daddr, input, ADDR_W: register address, sampled with den.
- din, input, DATA_W: write data, sampled with den.
- dout, output, DATA_W: read data.
- drdy, output, 1: single-cycle completion strobe.
- rst_pll, input, 1: modelled PLL reset, active-high.
- locked, output, 1: modelled lock indication.
- proto_err, output, 1: sticky protocol-violation flag.
- access_cnt, output, 8: count of completed transactions; wraps.

Behaviour:
- Reset (rst_n low, async) clears:
  - all register-file words to 0
  - dout=0, drdy=0, locked=0, proto_err=0, access_cnt=0
  - FSM to IDLE, latency counter and lock counter to 0
- Transaction FSM has two states, IDLE and BUSY.
- IDLE:
  - On den=1, capture dwe/daddr/din into holding registers, load latency counter with RDY_LATENCY-1, go to BUSY.
  - If RDY_LATENCY=1, go straight to the completion action on the next edge; drdy rises the cycle after den.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter is 0, perform the completion action in that cycle, then return to IDLE.
  - drdy is high exactly RDY_LATENCY cycles after the den cycle, for one cycle only.
- Completion action, read:
  - dout <= mem[addr], registered so it is valid in the drdy cycle.
  - dout holds its value until the next read completes.
  - Writes never change dout.
- Completion action, write:
  - mem[addr] <= din, committed on the edge that raises drdy.
  - A read of the same address issued in the cycle after drdy returns the new data.
- access_cnt increments by 1 on each drdy; 8'hFF wraps to 8'h00.
- Protocol errors, each setting proto_err=1 (sticky until rst_n):
  - den=1 while in BUSY: the request is ignored and the in-flight transaction completes unaffected.
  - den=1 in the same cycle as drdy: counts as BUSY; the request is ignored.
- Earliest legal next den is the cycle after drdy.
- dwe/daddr/din are don't-care whenever den=0.
- Lock model:
  - While rst_pll=1: locked=0 and the lock counter is held at 0.
  - After rst_pll falls, the counter increments each cycle; locked rises when the counter reaches LOCK_DELAY, i.e. LOCK_DELAY cycles after the first cycle with rst_pll=0.
  - locked then holds until rst_pll rises; it drops in the cycle after rst_pll is sampled high.
  - rst_pll reasserted mid-count restarts the count from 0.
  - The counter saturates; no wrap.
- DRP transactions are independent of rst_pll: accepted and completed regardless, subject to the optional feature.
- rst_n asserted mid-transaction aborts it: no drdy and no write commit.

Optional Feature:
- Macro: DRP_WRITE_LOCK_EN.
- Defined:
  - A write completing while rst_pll=0 (PLL running) is rejected: mem is unchanged.
  - drdy is still pulsed on schedule and access_cnt still increments.
  - proto_err is set.
- Undefined: writes commit regardless of rst_pll.
- Reads are unaffected in both cases.

Test Plan:
- Write then read back: RDY_LATENCY=3; write daddr=7'h08, din=16'h1041 at cycle 0 -> drdy at cycle 3. Read 7'h08 at cycle 4 -> drdy at cycle 7 with dout=16'h1041, access_cnt=2.
- Minimum latency: RDY_LATENCY=1; back-to-back read requests on alternating cycles to 7'h00 and 7'h7F after writes of 16'hAAAA and 16'h5555 -> each drdy one cycle after its den with the correct data, proto_err=0.
- Busy collision: den at cycle 0, den again at cycle 1 and at the drdy cycle -> single drdy at cycle 3, second and third requests dropped, proto_err=1, access_cnt=1.
- Lock timing: LOCK_DELAY=64; drop rst_pll at cycle 10 -> locked rises exactly at cycle 74. Pulse rst_pll high at cycle 40 for one cycle -> count restarts, locked stays 0 until 64 cycles after the new release.
- Reset mid-operation: assert rst_n low between den and drdy -> drdy never pulses; the target address reads 0 afterwards; locked=0, proto_err=0, access_cnt=0.
- DRP_WRITE_LOCK_EN defined, rst_pll=0: write 16'hBEEF to 7'h14 -> drdy pulses, proto_err=1, readback returns 0. Repeat with rst_pll=1 -> readback returns 16'hBEEF.
